// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop synchroniser, majority-voted bit sampling, parity/framing checks
// and a small receive FIFO whose head entry drives the registered outputs.
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned UART_BPS   = 128000,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned BIT_CNT = CLK_FREQ / UART_BPS;
    localparam int unsigned HALF    = BIT_CNT / 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned EW      = DATA_BITS + 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CNT - 1);
    localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] SMP_DEC  = CNT_W'(HALF + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4,
        BREAK = 3'd5
    } state_t;

    state_t               state, state_nxt;
    logic                 rxd_s1, rxd_s2, rxd_d;
    logic [CNT_W-1:0]     cnt;
    logic                 smp_a, smp_b;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_q;
    logic                 pe_q, fe_q;

    logic                 fall_c, wrap_c, decide_c, maj_c, push_c;
    logic                 fe_nxt_c, stop_last_c, par_x_c, par_err_c;
    logic [EW-1:0]        entry_c;

    // Synchroniser plus one delay stage for falling-edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign fall_c      = rxd_d & ~rxd_s2;
    assign wrap_c      = (cnt == CNT_LAST);
    assign decide_c    = (state != IDLE) && (cnt == SMP_DEC);
    assign maj_c       = (smp_a & smp_b) | (smp_a & rxd_s2) | (smp_b & rxd_s2);
    assign fe_nxt_c    = fe_q | ~maj_c;
    assign stop_last_c = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign par_x_c     = (^shift_q) ^ maj_c;
    assign par_err_c   = (PARITY == 1) ? ~par_x_c : (PARITY == 2) ? par_x_c : 1'b0;
    assign entry_c     = {fe_nxt_c, pe_q, shift_q};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_c    = 1'b0;
        case (state)
            IDLE:  if (fall_c) state_nxt = START;
            START: begin
                if (decide_c && maj_c) state_nxt = IDLE;
                else if (wrap_c)       state_nxt = DATA;
            end
            DATA:  if (wrap_c && bit_idx == IDX_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
            PAR:   if (wrap_c) state_nxt = STOP;
            STOP: begin
                // Frame is committed mid-way through the last stop bit so a back-to-back start edge is caught
                if (decide_c && stop_last_c) begin
                    push_c    = 1'b1;
                    state_nxt = (fe_nxt_c && !rxd_s2) ? BREAK : IDLE;
                end
            end
            BREAK: if (rxd_s2) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, sampling and frame assembly
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift_q  <= '0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else if (state == IDLE) begin
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
            if (cnt == SMP_A) smp_a <= rxd_s2;
            if (cnt == SMP_B) smp_b <= rxd_s2;
            if (decide_c) begin
                case (state)
                    DATA:    shift_q <= {maj_c, shift_q[DATA_BITS-1:1]};
                    PAR:     pe_q    <= par_err_c;
                    STOP:    if (!maj_c) fe_q <= 1'b1;
                    default: ;
                endcase
            end
            if (wrap_c && state == DATA) bit_idx  <= bit_idx + IDX_W'(1);
            if (wrap_c && state == STOP) stop_idx <= 1'b1;
        end
    end

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, used_c;
    logic [AW-1:0] rd_next_idx_c;
    logic [EW-1:0] head_q, head_nxt_c;
    logic          empty_c, full_c, pop_c, wr_en_c, valid_nxt_c;

    assign used_c        = wr_ptr - rd_ptr;
    assign empty_c       = (used_c == '0);
    assign full_c        = (used_c == PW'(FIFO_DEPTH));
    assign pop_c         = rx_valid & rx_ready;
    assign wr_en_c       = push_c & (~full_c | pop_c);
    assign rd_next_idx_c = rd_ptr[AW-1:0] + AW'(1);

    // Next head entry, kept in a register so the outputs come straight from flops
    always_comb begin
        head_nxt_c  = head_q;
        valid_nxt_c = rx_valid;
        if (pop_c) begin
            if (used_c > PW'(1)) begin
                head_nxt_c  = mem[rd_next_idx_c];
                valid_nxt_c = 1'b1;
            end else if (wr_en_c) begin
                head_nxt_c  = entry_c;
                valid_nxt_c = 1'b1;
            end else begin
                head_nxt_c  = '0;
                valid_nxt_c = 1'b0;
            end
        end else if (wr_en_c && empty_c) begin
            head_nxt_c  = entry_c;
            valid_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head_q   <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr[AW-1:0]] <= entry_c;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PW'(1);
            head_q   <= head_nxt_c;
            rx_valid <= valid_nxt_c;
            overrun  <= push_c & full_c & ~pop_c;
            busy     <= (state_nxt != IDLE);
        end
    end

    assign {frame_err, parity_err, rx_data} = head_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames are driven on three instances and
// received entries are checked against a per-instance scoreboard queue.
module tb_uart_rx_fifo;
    localparam int unsigned BC0 = 781;  // default 100 MHz / 128000
    localparam int unsigned BCF = 50;   // 100 MHz / 2 Mbaud

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    logic       rxd0, rxd1, rxd2;
    logic       ready0, ready1, ready2;
    logic [7:0] data0, data1;
    logic [6:0] data2;
    logic       valid0, valid1, valid2;
    logic       pe0, pe1, pe2, fe0, fe1, fe2;
    logic       ovr0, ovr1, ovr2, busy0, busy1, busy2;

    int n_chk  = 0;
    int n_fail = 0;
    int ovr_cnt1 = 0;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];

    uart_rx_fifo dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd0),
        .rx_data(data0), .rx_valid(valid0), .rx_ready(ready0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ovr0), .busy(busy0)
    );

    uart_rx_fifo #(.CLK_FREQ(100_000_000), .UART_BPS(2_000_000)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd1),
        .rx_data(data1), .rx_valid(valid1), .rx_ready(ready1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ovr1), .busy(busy1)
    );

    uart_rx_fifo #(.CLK_FREQ(100_000_000), .UART_BPS(2_000_000), .DATA_BITS(7), .PARITY(2)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_rxd(rxd2),
        .rx_data(data2), .rx_valid(valid2), .rx_ready(ready2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ovr2), .busy(busy2)
    );

    always @(negedge sys_clk) if (ovr1) ovr_cnt1 <= ovr_cnt1 + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input int sel, input logic v);
        case (sel)
            0:       rxd0 = v;
            1:       rxd1 = v;
            default: rxd2 = v;
        endcase
    endtask

    task automatic set_ready(input int sel, input logic v);
        case (sel)
            0:       ready0 = v;
            1:       ready1 = v;
            default: ready2 = v;
        endcase
    endtask

    function automatic logic [10:0] head(input int sel);
        case (sel)
            0:       head = {valid0, fe0, pe0, data0};
            1:       head = {valid1, fe1, pe1, data1};
            default: head = {valid2, fe2, pe2, 1'b0, data2};
        endcase
    endfunction

    task automatic put_bit(input int sel, input int unsigned bc, input logic v);
        set_line(sel, v);
        repeat (bc) @(negedge sys_clk);
    endtask

    // Drives one frame; pmode 0 none / 1 odd / 2 even. Expected entry goes to the scoreboard when exp_it.
    task automatic send_frame(input int sel, input int unsigned bc, input int nbits, input logic [7:0] d,
                              input int pmode, input logic bad_par, input logic stop_v, input logic exp_it);
        logic       xr;
        logic       pbit;
        logic       pe_exp;
        logic [7:0] dm;
        logic [9:0] e;
        xr = 1'b0;
        dm = '0;
        pbit = 1'b0;
        put_bit(sel, bc, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            xr    = xr ^ d[i];
            dm[i] = d[i];
            put_bit(sel, bc, d[i]);
        end
        pe_exp = 1'b0;
        if (pmode != 0) begin
            pbit = (pmode == 2) ? xr : ~xr;
            if (bad_par) pbit = ~pbit;
            pe_exp = (pmode == 1) ? ~(xr ^ pbit) : (xr ^ pbit);
            put_bit(sel, bc, pbit);
        end
        put_bit(sel, bc, stop_v);
        e = {~stop_v, pe_exp, dm};
        if (exp_it) begin
            case (sel)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // Waits (bounded) for a head entry, compares it with the scoreboard, then pops it for one cycle
    task automatic pop_check(input int sel, input string tag);
        logic [10:0] h;
        logic [9:0]  e;
        int          n;
        n = 0;
        h = head(sel);
        while (!h[10] && n < 2000) begin
            @(negedge sys_clk);
            n++;
            h = head(sel);
        end
        chk({tag, "_valid"}, 32'(h[10]), 32'(1));
        e = 10'h3ff;
        case (sel)
            0:       if (q0.size() > 0) e = q0.pop_front();
            1:       if (q1.size() > 0) e = q1.pop_front();
            default: if (q2.size() > 0) e = q2.pop_front();
        endcase
        chk(tag, 32'(h[9:0]), 32'(e));
        set_ready(sel, 1'b1);
        @(negedge sys_clk);
        set_ready(sel, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        int         base;
        sys_rst_n = 1'b0;
        rxd0 = 1'b1; rxd1 = 1'b1; rxd2 = 1'b1;
        ready0 = 1'b0; ready1 = 1'b0; ready2 = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("rst_valid", 32'(valid0), 32'(0));
        chk("rst_data", 32'(data0), 32'(0));
        chk("rst_busy", 32'(busy0), 32'(0));
        chk("rst_flags", 32'({pe0, fe0, ovr0}), 32'(0));
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Default configuration, single frame then pop
        send_frame(0, BC0, 8, 8'hA5, 0, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge sys_clk);
        chk("a5_held", 32'(head(0)), 32'({1'b1, 2'b00, 8'hA5}));
        pop_check(0, "a5_head");
        chk("a5_popped_valid", 32'(valid0), 32'(0));
        chk("a5_popped_data", 32'(data0), 32'(0));

        // Short low glitch is a false start
        set_line(0, 1'b0);
        repeat (50) @(negedge sys_clk);
        chk("glitch_busy", 32'(busy0), 32'(1));
        repeat (50) @(negedge sys_clk);
        set_line(0, 1'b1);
        repeat (BC0) @(negedge sys_clk);
        chk("glitch_idle", 32'(busy0), 32'(0));
        chk("glitch_nowrite", 32'(valid0), 32'(0));

        // Even parity, 7 data bits: wrong then correct parity bit
        send_frame(2, BCF, 7, 8'h35, 2, 1'b1, 1'b1, 1'b1);
        send_frame(2, BCF, 7, 8'h35, 2, 1'b0, 1'b1, 1'b1);
        pop_check(2, "par_bad");
        pop_check(2, "par_good");
        chk("par_empty", 32'(valid2), 32'(0));

        // Stop bit low followed by a held-low line
        send_frame(1, BCF, 8, 8'hC3, 0, 1'b0, 1'b0, 1'b1);
        repeat (3 * BCF) @(negedge sys_clk);
        chk("brk_busy", 32'(busy1), 32'(1));
        chk("brk_fe", 32'(fe1), 32'(1));
        pop_check(1, "brk_frame");
        repeat (BCF) @(negedge sys_clk);
        chk("brk_nodecode", 32'(valid1), 32'(0));
        chk("brk_still_busy", 32'(busy1), 32'(1));
        set_line(1, 1'b1);
        repeat (2 * BCF) @(negedge sys_clk);
        chk("brk_released", 32'(busy1), 32'(0));
        send_frame(1, BCF, 8, 8'h3C, 0, 1'b0, 1'b1, 1'b1);
        pop_check(1, "brk_next");

        // Five back-to-back frames into a 4-entry FIFO
        base = ovr_cnt1;
        for (int i = 1; i <= 4; i++) send_frame(1, BCF, 8, 8'(i), 0, 1'b0, 1'b1, 1'b1);
        chk("ovr_none", 32'(ovr_cnt1 - base), 32'(0));
        send_frame(1, BCF, 8, 8'h05, 0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge sys_clk);
        chk("ovr_pulse", 32'(ovr_cnt1 - base), 32'(1));
        for (int i = 1; i <= 4; i++) pop_check(1, "ovr_pop");
        chk("ovr_empty", 32'(valid1), 32'(0));

        // Reset during data bit 4 with an entry already queued
        send_frame(0, BC0, 8, 8'h11, 0, 1'b0, 1'b1, 1'b1);
        repeat (10) @(negedge sys_clk);
        chk("pre_rst_valid", 32'(valid0), 32'(1));
        d = 8'hE7;
        put_bit(0, BC0, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(0, BC0, d[i]);
        set_line(0, d[4]);
        repeat (BC0 / 2) @(negedge sys_clk);
        chk("mid_busy", 32'(busy0), 32'(1));
        sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_head", 32'(head(0)), 32'(0));
        chk("mid_rst_busy_ovr", 32'({busy0, ovr0}), 32'(0));
        q0.delete();
        set_line(0, 1'b1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (BC0) @(negedge sys_clk);
        chk("post_rst_idle", 32'({busy0, valid0}), 32'(0));
        send_frame(0, BC0, 8, 8'h5A, 0, 1'b0, 1'b1, 1'b1);
        pop_check(0, "post_rst_5a");
        chk("post_rst_empty", 32'(valid0), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
